// File: rtl/branch_predictor_bht_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_bht_pkg
// Shared definitions for the branch target buffer: default geometry, the
// derived default index width, and helpers that compute the counter
// reset (weakly-not-taken) and allocation (weakly-taken) values for any
// counter width.
// -----------------------------------------------------------------------------
package branch_predictor_bht_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int ENTRIES_DEF  = 16;
    localparam int TAG_BITS_DEF = 8;
    localparam int CTR_BITS_DEF = 2;
    localparam int IDX_DEF      = $clog2(ENTRIES_DEF);

    // Weakly-not-taken: one below the taken threshold (0 for a 1-bit counter).
    function automatic int ctr_reset_val(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    // Weakly-taken: the smallest value whose MSB is set.
    function automatic int ctr_alloc_val(input int bits);
        return 1 << (bits - 1);
    endfunction

endpackage

// File: rtl/branch_predictor_bht_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_bht_if
// Bundles the lookup (IF stage), update (MEM stage), maintenance and
// statistics signals of the branch predictor.
//   master : fetch/resolve side, drives lookup, update, flush, stat_clear
//   slave  : predictor, drives hit/prediction and statistics outputs
// -----------------------------------------------------------------------------
interface branch_predictor_bht_if
    import branch_predictor_bht_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    // Lookup
    logic            lookup_valid_i;
    logic [XLEN-1:0] lookup_pc_i;
    logic            hit_o;
    logic            predict_taken_o;
    logic [XLEN-1:0] predict_target_o;
    // Update
    logic            update_valid_i;
    logic [XLEN-1:0] update_pc_i;
    logic            update_taken_i;
    logic [XLEN-1:0] update_target_i;
    logic            update_mispredict_i;
    // Maintenance and statistics
    logic            flush_i;
    logic            stat_clear_i;
    logic [31:0]     stat_branches_o;
    logic [31:0]     stat_mispredicts_o;

    modport master (
        output lookup_valid_i, lookup_pc_i,
        output update_valid_i, update_pc_i, update_taken_i,
        output update_target_i, update_mispredict_i,
        output flush_i, stat_clear_i,
        input  hit_o, predict_taken_o, predict_target_o,
        input  stat_branches_o, stat_mispredicts_o
    );

    modport slave (
        input  lookup_valid_i, lookup_pc_i,
        input  update_valid_i, update_pc_i, update_taken_i,
        input  update_target_i, update_mispredict_i,
        input  flush_i, stat_clear_i,
        output hit_o, predict_taken_o, predict_target_o,
        output stat_branches_o, stat_mispredicts_o
    );

endinterface

// File: rtl/branch_predictor_bht_sat_counter.sv
// -----------------------------------------------------------------------------
// bp_sat_counter
// CTR_BITS-wide saturating up/down counter with a parallel load.
//   clk, rst_n : clock and asynchronous active-low reset (to RESET_VAL)
//   inc, dec   : step up / down, holding at all-ones / zero
//   load       : take load_val (highest priority)
//   count      : current value
// -----------------------------------------------------------------------------
module bp_sat_counter #(
    parameter int CTR_BITS  = 2,
    parameter int RESET_VAL = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                dec,
    input  logic                load,
    input  logic [CTR_BITS-1:0] load_val,
    output logic [CTR_BITS-1:0] count
);

    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    // NOTE: state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= CTR_BITS'(RESET_VAL);
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count != CTR_MAX)) begin
            count <= count + CTR_BITS'(1);
        end else if (dec && (count != '0)) begin
            count <= count - CTR_BITS'(1);
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// branch_predictor_bht
// Direct-mapped branch target buffer with per-entry saturating counters.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   bus (slave)      : combinational lookup by fetch PC, registered update
//                      from branch resolution, flush, and 32-bit branch /
//                      mispredict statistics counters
// PC fields: index = pc[IDX+1:2], tag = pc[IDX+TAG_BITS+1:IDX+2].
// -----------------------------------------------------------------------------
module branch_predictor_bht
    import branch_predictor_bht_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int ENTRIES  = ENTRIES_DEF,
    parameter int TAG_BITS = TAG_BITS_DEF,
    parameter int CTR_BITS = CTR_BITS_DEF
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    branch_predictor_bht_if.slave bus
);

    localparam int IDX    = $clog2(ENTRIES);
    localparam int TAG_LO = IDX + 2;
    localparam int TAG_HI = IDX + TAG_BITS + 1;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr      [ENTRIES];

    logic [IDX-1:0]      lookup_idx;
    logic [TAG_BITS-1:0] lookup_tag;
    logic [IDX-1:0]      update_idx;
    logic [TAG_BITS-1:0] update_tag;
    logic                update_hit;
    logic                update_en;

    assign lookup_idx = bus.lookup_pc_i[IDX+1:2];
    assign lookup_tag = bus.lookup_pc_i[TAG_HI:TAG_LO];
    assign update_idx = bus.update_pc_i[IDX+1:2];
    assign update_tag = bus.update_pc_i[TAG_HI:TAG_LO];

    // Bits of the update PC outside index/tag do not take part in matching.
    logic unused_update_lo;
    assign unused_update_lo = ^bus.update_pc_i[1:0];
    if (TAG_HI + 1 < XLEN) begin : g_unused_hi
        logic unused_update_hi;
        assign unused_update_hi = ^bus.update_pc_i[XLEN-1:TAG_HI+1];
    end

    // ---------------------------------------------------------------- lookup
    // NOTE: every output gets a default first so always_comb cannot infer a latch.
    always_comb begin
        bus.hit_o            = 1'b0;
        bus.predict_taken_o  = 1'b0;
        bus.predict_target_o = bus.lookup_pc_i + XLEN'(4);
        if (bus.lookup_valid_i && valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag)) begin
            bus.hit_o = 1'b1;
            if (ctr[lookup_idx][CTR_BITS-1]) begin
                bus.predict_taken_o  = 1'b1;
                bus.predict_target_o = target_q[lookup_idx];
            end
        end
    end

    // ---------------------------------------------------------------- update
    assign update_hit = valid_q[update_idx] && (tag_q[update_idx] == update_tag);
    // Flush wins: a same-cycle update must leave no trace in the table.
    assign update_en  = bus.update_valid_i && !bus.flush_i;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        logic sel;
        assign sel = update_en && (update_idx == IDX'(g));

        bp_sat_counter #(
            .CTR_BITS  (CTR_BITS),
            .RESET_VAL (ctr_reset_val(CTR_BITS))
        ) u_ctr (
            .clk      (clk_i),
            .rst_n    (reset_n_i),
            .inc      (sel && update_hit && bus.update_taken_i),
            .dec      (sel && update_hit && !bus.update_taken_i),
            .load     (sel && !update_hit && bus.update_taken_i),
            .load_val (CTR_BITS'(ctr_alloc_val(CTR_BITS))),
            .count    (ctr[g])
        );
    end

    // NOTE: the table arrays are reset explicitly because reset must leave
    // tags and targets at 0, not merely invalid.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else if (bus.flush_i) begin
            // Tags and targets stay; with valid cleared they are unreachable.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (bus.update_valid_i) begin
            if (update_hit) begin
                if (bus.update_taken_i) begin
                    target_q[update_idx] <= bus.update_target_i;
                end
            end else if (bus.update_taken_i) begin
                valid_q[update_idx]  <= 1'b1;
                tag_q[update_idx]    <= update_tag;
                target_q[update_idx] <= bus.update_target_i;
            end
        end
    end

    // ------------------------------------------------------------ statistics
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bus.stat_branches_o    <= '0;
            bus.stat_mispredicts_o <= '0;
        end else if (bus.stat_clear_i) begin
            bus.stat_branches_o    <= '0;
            bus.stat_mispredicts_o <= '0;
        end else if (bus.update_valid_i) begin
            bus.stat_branches_o <= bus.stat_branches_o + 32'd1;
            if (bus.update_mispredict_i) begin
                bus.stat_mispredicts_o <= bus.stat_mispredicts_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor_bht
// Directed scenarios with fixed expected values, followed by a randomized
// run compared against a table model kept in plain arrays.
// -----------------------------------------------------------------------------
module tb_branch_predictor_bht;
    import branch_predictor_bht_pkg::*;

    localparam int ENTRIES  = ENTRIES_DEF;
    localparam int IDX      = IDX_DEF;
    localparam int TAG_BITS = TAG_BITS_DEF;
    localparam int CTR_BITS = CTR_BITS_DEF;
    localparam int CTR_MAX  = (1 << CTR_BITS) - 1;
    localparam int CTR_THR  = 1 << (CTR_BITS - 1);

    logic clk_i;
    logic reset_n_i;
    int   n_run;
    int   n_fail;

    branch_predictor_bht_if bus ();

    branch_predictor_bht dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .bus       (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ------------------------------------------------------- reference model
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    logic [31:0] m_br;
    logic [31:0] m_mp;

    function automatic int pc_idx(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic int unsigned pc_tag(input logic [31:0] pc);
        return (pc / (4 * ENTRIES)) % (1 << TAG_BITS);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < ENTRIES; k++) begin
            m_valid[k]  = 1'b0;
            m_tag[k]    = 0;
            m_target[k] = 32'h0;
            m_ctr[k]    = CTR_THR - 1;
        end
        m_br = 32'h0;
        m_mp = 32'h0;
    endtask

    // Applies the effect of the inputs currently driven at the coming edge.
    task automatic model_apply();
        int i;
        int unsigned t;
        if (bus.stat_clear_i === 1'b1) begin
            m_br = 32'h0;
            m_mp = 32'h0;
        end else if (bus.update_valid_i === 1'b1) begin
            m_br = m_br + 32'd1;
            if (bus.update_mispredict_i) m_mp = m_mp + 32'd1;
        end
        if (bus.flush_i === 1'b1) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
        end else if (bus.update_valid_i === 1'b1) begin
            i = pc_idx(bus.update_pc_i);
            t = pc_tag(bus.update_pc_i);
            if (m_valid[i] && m_tag[i] == t) begin
                if (bus.update_taken_i) begin
                    m_ctr[i]    = (m_ctr[i] < CTR_MAX) ? m_ctr[i] + 1 : CTR_MAX;
                    m_target[i] = bus.update_target_i;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (bus.update_taken_i) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = t;
                m_target[i] = bus.update_target_i;
                m_ctr[i]    = CTR_THR;
            end
        end
    endtask

    function automatic logic [33:0] model_lookup(input logic lv, input logic [31:0] pc);
        int  i;
        logic h;
        logic tk;
        i  = pc_idx(pc);
        h  = lv && m_valid[i] && (m_tag[i] == pc_tag(pc));
        tk = h && (m_ctr[i] >= CTR_THR);
        return {h, tk, tk ? m_target[i] : pc + 32'd4};
    endfunction

    // --------------------------------------------------------------- helpers
    function automatic logic [33:0] obs();
        return {bus.hit_o, bus.predict_taken_o, bus.predict_target_o};
    endfunction

    function automatic logic [63:0] obs_stats();
        return {bus.stat_branches_o, bus.stat_mispredicts_o};
    endfunction

    task automatic idle();
        bus.update_valid_i      = 1'b0;
        bus.update_pc_i         = 32'h0;
        bus.update_taken_i      = 1'b0;
        bus.update_target_i     = 32'h0;
        bus.update_mispredict_i = 1'b0;
        bus.flush_i             = 1'b0;
        bus.stat_clear_i        = 1'b0;
    endtask

    task automatic tick();
        model_apply();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_update(input logic [31:0] pc, input logic tk,
                              input logic [31:0] tgt, input logic mis);
        bus.update_valid_i      = 1'b1;
        bus.update_pc_i         = pc;
        bus.update_taken_i      = tk;
        bus.update_target_i     = tgt;
        bus.update_mispredict_i = mis;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic mis);
        set_update(pc, tk, tgt, mis);
        tick();
        idle();
    endtask

    task automatic look(input logic [31:0] pc);
        bus.lookup_valid_i = 1'b1;
        bus.lookup_pc_i    = pc;
        #1;
    endtask

    // ------------------------------------------------------------- scenarios
    task automatic test_reset();
        look(32'h100);
        n_run++;
        if (obs() !== {1'b0, 1'b0, 32'h104}) begin
            n_fail++;
            $display("FAIL reset_lookup: got %h want %h", obs(), {1'b0, 1'b0, 32'h104});
        end
        n_run++;
        if (obs_stats() !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_stats: got %h want %h", obs_stats(), 64'h0);
        end
    endtask

    task automatic test_train();
        upd(32'h100, 1'b1, 32'h80, 1'b0);
        look(32'h100);
        n_run++;
        if (obs() !== {1'b1, 1'b1, 32'h80}) begin
            n_fail++;
            $display("FAIL train_alloc: got %h want %h", obs(), {1'b1, 1'b1, 32'h80});
        end
        bus.lookup_valid_i = 1'b0;
        #1;
        n_run++;
        if (obs() !== {1'b0, 1'b0, 32'h104}) begin
            n_fail++;
            $display("FAIL lookup_invalid: got %h want %h", obs(), {1'b0, 1'b0, 32'h104});
        end
        upd(32'h100, 1'b0, 32'h999, 1'b1);
        look(32'h100);
        n_run++;
        if (obs() !== {1'b1, 1'b0, 32'h104}) begin
            n_fail++;
            $display("FAIL train_ctr1: got %h want %h", obs(), {1'b1, 1'b0, 32'h104});
        end
        upd(32'h100, 1'b0, 32'h999, 1'b1);
        look(32'h100);
        n_run++;
        if (obs() !== {1'b1, 1'b0, 32'h104}) begin
            n_fail++;
            $display("FAIL train_ctr0: got %h want %h", obs(), {1'b1, 1'b0, 32'h104});
        end
    endtask

    task automatic test_saturation();
        logic [33:0] want [5];
        logic [31:0] tgts [4];
        tgts[0] = 32'h1000; tgts[1] = 32'h2000; tgts[2] = 32'h3000; tgts[3] = 32'h4000;
        want[0] = {1'b1, 1'b0, 32'h104};     // ctr 1
        want[1] = {1'b1, 1'b1, 32'h2000};    // ctr 2
        want[2] = {1'b1, 1'b1, 32'h3000};    // ctr 3
        want[3] = {1'b1, 1'b1, 32'h4000};    // ctr 3 (held)
        want[4] = {1'b1, 1'b1, 32'h4000};    // one not-taken from 3 -> 2
        for (int k = 0; k < 5; k++) begin
            if (k < 4) upd(32'h100, 1'b1, tgts[k], 1'b0);
            else       upd(32'h100, 1'b0, 32'h5000, 1'b0);
            look(32'h100);
            n_run++;
            if (obs() !== want[k]) begin
                n_fail++;
                $display("FAIL saturate_step%0d: got %h want %h", k, obs(), want[k]);
            end
        end
        look(32'hFFFF_FFFC);
        n_run++;
        if (obs() !== {1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL pc_wrap: got %h want %h", obs(), {1'b0, 1'b0, 32'h0});
        end
    endtask

    task automatic test_alias();
        look(32'h140);
        n_run++;
        if (obs() !== {1'b0, 1'b0, 32'h144}) begin
            n_fail++;
            $display("FAIL alias_miss: got %h want %h", obs(), {1'b0, 1'b0, 32'h144});
        end
        upd(32'h140, 1'b1, 32'h200, 1'b0);
        look(32'h140);
        n_run++;
        if (obs() !== {1'b1, 1'b1, 32'h200}) begin
            n_fail++;
            $display("FAIL alias_replace: got %h want %h", obs(), {1'b1, 1'b1, 32'h200});
        end
        look(32'h100);
        n_run++;
        if (obs() !== {1'b0, 1'b0, 32'h104}) begin
            n_fail++;
            $display("FAIL alias_evicted: got %h want %h", obs(), {1'b0, 1'b0, 32'h104});
        end
        upd(32'h208, 1'b0, 32'h300, 1'b0);
        upd(32'h180, 1'b0, 32'h300, 1'b0);
        look(32'h208);
        n_run++;
        if (obs() !== {1'b0, 1'b0, 32'h20C}) begin
            n_fail++;
            $display("FAIL nt_miss_noalloc: got %h want %h", obs(), {1'b0, 1'b0, 32'h20C});
        end
        look(32'h140);
        n_run++;
        if (obs() !== {1'b1, 1'b1, 32'h200}) begin
            n_fail++;
            $display("FAIL nt_miss_keep: got %h want %h", obs(), {1'b1, 1'b1, 32'h200});
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] pcs [3];
        pcs[0] = 32'h100; pcs[1] = 32'h180; pcs[2] = 32'h140;
        // Update and lookup of the same entry in one cycle: no bypass.
        set_update(32'h100, 1'b1, 32'h500, 1'b0);
        look(32'h100);
        n_run++;
        if (obs() !== {1'b0, 1'b0, 32'h104}) begin
            n_fail++;
            $display("FAIL no_bypass: got %h want %h", obs(), {1'b0, 1'b0, 32'h104});
        end
        tick();
        idle();
        #1;
        n_run++;
        if (obs() !== {1'b1, 1'b1, 32'h500}) begin
            n_fail++;
            $display("FAIL after_update: got %h want %h", obs(), {1'b1, 1'b1, 32'h500});
        end
        // Flush together with an allocating update leaves the table empty.
        set_update(32'h180, 1'b1, 32'h600, 1'b0);
        bus.flush_i = 1'b1;
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            look(pcs[k]);
            n_run++;
            if (obs() !== {1'b0, 1'b0, pcs[k] + 32'd4}) begin
                n_fail++;
                $display("FAIL flush_miss_%h: got %h want %h", pcs[k], obs(), {1'b0, 1'b0, pcs[k] + 32'd4});
            end
        end
        // Asynchronous reset between edges clears outputs at once.
        upd(32'h100, 1'b1, 32'h700, 1'b1);
        look(32'h100);
        n_run++;
        if (obs() !== {1'b1, 1'b1, 32'h700}) begin
            n_fail++;
            $display("FAIL pre_reset: got %h want %h", obs(), {1'b1, 1'b1, 32'h700});
        end
        reset_n_i = 1'b0;
        #1;
        model_reset();
        n_run++;
        if (obs() !== {1'b0, 1'b0, 32'h104}) begin
            n_fail++;
            $display("FAIL async_reset_lookup: got %h want %h", obs(), {1'b0, 1'b0, 32'h104});
        end
        n_run++;
        if (obs_stats() !== 64'h0) begin
            n_fail++;
            $display("FAIL async_reset_stats: got %h want %h", obs_stats(), 64'h0);
        end
        #2;
        reset_n_i = 1'b1;
        tick();
    endtask

    task automatic test_stats();
        logic mis [5];
        mis[0] = 1'b0; mis[1] = 1'b1; mis[2] = 1'b0; mis[3] = 1'b1; mis[4] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            upd(32'h300 + 32'(k * 4), k[0], 32'h800, mis[k]);
        end
        n_run++;
        if (obs_stats() !== {32'd5, 32'd2}) begin
            n_fail++;
            $display("FAIL stats_count: got %h want %h", obs_stats(), {32'd5, 32'd2});
        end
        set_update(32'h304, 1'b1, 32'h800, 1'b1);
        bus.stat_clear_i = 1'b1;
        tick();
        idle();
        n_run++;
        if (obs_stats() !== 64'h0) begin
            n_fail++;
            $display("FAIL stats_clear_wins: got %h want %h", obs_stats(), 64'h0);
        end
        bus.update_valid_i      = 1'b0;
        bus.update_pc_i         = 'x;
        bus.update_taken_i      = 'x;
        bus.update_target_i     = 'x;
        bus.update_mispredict_i = 1'b1;
        tick();
        idle();
        n_run++;
        if (obs_stats() !== 64'h0) begin
            n_fail++;
            $display("FAIL stats_invalid_update: got %h want %h", obs_stats(), 64'h0);
        end
        upd(32'h308, 1'b0, 32'h0, 1'b1);
        bus.flush_i = 1'b1;
        tick();
        idle();
        n_run++;
        if (obs_stats() !== {32'd1, 32'd1}) begin
            n_fail++;
            $display("FAIL stats_flush_keep: got %h want %h", obs_stats(), {32'd1, 32'd1});
        end
    endtask

    task automatic test_random();
        logic [31:0] pc;
        logic [33:0] exp_l;
        for (int n = 0; n < 400; n++) begin
            // Few tags per index so hits, aliasing and replacement all occur.
            pc = ($urandom_range(0, 3) << (IDX + 2)) | ($urandom_range(0, ENTRIES - 1) << 2)
                 | $urandom_range(0, 3) | (($urandom_range(0, 1) * $urandom()) & 32'hFFFF_C000);
            bus.lookup_valid_i = ($urandom_range(0, 9) != 0);
            bus.lookup_pc_i    = pc;
            if ($urandom_range(0, 9) < 6) begin
                pc = ($urandom_range(0, 3) << (IDX + 2)) | ($urandom_range(0, ENTRIES - 1) << 2)
                     | $urandom_range(0, 3);
                set_update(pc, 1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC,
                           1'($urandom_range(0, 1)));
            end else begin
                bus.update_valid_i = 1'b0;
            end
            bus.flush_i      = ($urandom_range(0, 29) == 0);
            bus.stat_clear_i = ($urandom_range(0, 29) == 0);
            #1;
            exp_l = model_lookup(bus.lookup_valid_i, bus.lookup_pc_i);
            n_run++;
            if (obs() !== exp_l) begin
                n_fail++;
                $display("FAIL rand_lookup[%0d] pc=%h: got %h want %h", n, bus.lookup_pc_i, obs(), exp_l);
            end
            n_run++;
            if (obs_stats() !== {m_br, m_mp}) begin
                n_fail++;
                $display("FAIL rand_stats[%0d]: got %h want %h", n, obs_stats(), {m_br, m_mp});
            end
            tick();
            idle();
        end
    endtask

    // ------------------------------------------------------------------ main
    initial begin
        n_run  = 0;
        n_fail = 0;
        reset_n_i          = 1'b0;
        bus.lookup_valid_i = 1'b0;
        bus.lookup_pc_i    = 32'h0;
        idle();
        model_reset();
        #12;
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        test_reset();
        test_train();
        test_saturation();
        test_alias();
        test_same_cycle();
        test_stats();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
